// File: rtl/conv33_window_gen.sv
// conv33_window_gen
// Streaming 3x3 window generator feeding conv33_6bit_PIM. Raster-ordered
// pixels enter one per handshake. Two line buffers hold the previous two
// rows, and every complete 3x3 neighbourhood is presented as nine parallel
// taps through a single registered output stage with backpressure.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   in_pixel         - raster-order pixel (row-major, left to right)
//   in_valid         - in_pixel is valid
//   in_ready         - block accepts a pixel this cycle
//   win_0..win_8     - window taps, row-major; win_0 = (r-2,c-2), win_8 = (r,c)
//   out_valid        - taps hold a valid window
//   out_ready        - downstream consumes the window
//   out_row, out_col - coordinates of the window centre
//   frame_done       - one-cycle pulse after the last pixel of a frame
module conv33_window_gen #(
  parameter int DATA_W = 6,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  localparam int ROW_W = $clog2(IMG_H),
  localparam int COL_W = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] win_0,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              frame_done
);

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] shift_win [9];
  logic [DATA_W-1:0] next_win  [9];
  logic [DATA_W-1:0] out_win   [9];

  logic [ROW_W-1:0] r;
  logic [COL_W-1:0] c;

  logic accept;
  logic emit;
  logic last_col;
  logic last_row;

  // The input stalls whenever a window is held and not being consumed, even
  // if the incoming pixel would not itself produce a window.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (c == COL_W'(IMG_W - 1));
  assign last_row = (r == ROW_W'(IMG_H - 1));

  // Gating on r>=2 and c>=2 ensures all nine taps belong to the current
  // frame, so stale buffer contents never reach the output.
  assign emit = accept && (r >= ROW_W'(2)) && (c >= COL_W'(2));

  // Post-shift window: each row moves left by one and the new right-hand
  // column comes from the line buffers (read before they are overwritten)
  // plus the incoming pixel.
  always_comb begin
    next_win[0] = shift_win[1];
    next_win[1] = shift_win[2];
    next_win[2] = lb1[c];
    next_win[3] = shift_win[4];
    next_win[4] = shift_win[5];
    next_win[5] = lb0[c];
    next_win[6] = shift_win[7];
    next_win[7] = shift_win[8];
    next_win[8] = in_pixel;
  end

  // Line buffers and the shift register carry no reset; their contents are
  // only observed through emit-gated loads.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[c]    <= lb0[c];
      lb0[c]    <= in_pixel;
      shift_win <= next_win;
    end
  end

  // Raster counters, output register and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r          <= '0;
      c          <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < 9; i++) out_win[i] <= '0;
    end else begin
      frame_done <= accept && last_row && last_col;

      if (accept) begin
        if (last_col) begin
          c <= '0;
          r <= last_row ? '0 : r + ROW_W'(1);
        end else begin
          c <= c + COL_W'(1);
        end
      end

      // A new window may replace one being consumed in the same cycle, which
      // keeps out_valid high with no bubble.
      if (emit) begin
        out_win   <= next_win;
        out_row   <= r - ROW_W'(1);
        out_col   <= c - COL_W'(1);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign win_0 = out_win[0];
  assign win_1 = out_win[1];
  assign win_2 = out_win[2];
  assign win_3 = out_win[3];
  assign win_4 = out_win[4];
  assign win_5 = out_win[5];
  assign win_6 = out_win[6];
  assign win_7 = out_win[7];
  assign win_8 = out_win[8];

endmodule

// File: tb/tb_conv33_window_gen.sv
// tb_conv33_window_gen
// Self-checking bench for conv33_window_gen on a 4x4 image. A behavioural
// model stores the whole frame in a 2-D image array and builds each window
// directly from image coordinates. A compare process checks every DUT output
// against that model on every falling edge. Literal expectations pin the
// model at key points.
module tb_conv33_window_gen;

  localparam int DW = 6;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          frame_done;

  always #5 clk = ~clk;

  conv33_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .win_0(win_0), .win_1(win_1), .win_2(win_2),
    .win_3(win_3), .win_4(win_4), .win_5(win_5),
    .win_6(win_6), .win_7(win_7), .win_8(win_8),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  wire [9*DW-1:0] dut_taps = {win_0, win_1, win_2, win_3, win_4,
                              win_5, win_6, win_7, win_8};

  int tests_run  = 0;
  int failures   = 0;
  bit checking   = 0;
  int win_count  = 0;
  int done_count = 0;

  // Behavioural model state
  logic [DW-1:0]   img [H][W];
  int              mr, mc;
  bit              m_valid, m_done, m_acc;
  logic [9*DW-1:0] m_taps;
  int              m_row, m_col;

  function automatic logic [9*DW-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5), 6'(a6), 6'(a7), 6'(a8)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: on each accepted pixel, record it at (row, col) in the frame
  // image; once row and col are both >= 2 the window is read straight out of
  // the image around that position.
  always @(posedge clk) begin
    if (rst) begin
      mr = 0; mc = 0; m_valid = 0; m_done = 0;
      m_taps = '0; m_row = 0; m_col = 0;
    end else begin
      m_acc  = in_valid && (!m_valid || out_ready);
      m_done = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (m_acc) begin
        img[mr][mc] = in_pixel;
        if (mr >= 2 && mc >= 2) begin
          m_taps = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              m_taps = {m_taps[8*DW-1:0], img[mr-2+dr][mc-2+dc]};
          m_valid = 1;
          m_row   = mr - 1;
          m_col   = mc - 1;
        end
        if (mc == W - 1) begin
          mc = 0;
          if (mr == H - 1) begin
            mr = 0;
            m_done = 1;
          end else begin
            mr++;
          end
        end else begin
          mc++;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("in_ready",   64'(in_ready),   64'(!m_valid || out_ready));
      checkOutput("out_valid",  64'(out_valid),  64'(m_valid));
      checkOutput("frame_done", 64'(frame_done), 64'(m_done));
      checkOutput("taps",       64'(dut_taps),   64'(m_taps));
      checkOutput("out_row",    64'(out_row),    64'(m_row));
      checkOutput("out_col",    64'(out_col),    64'(m_col));
      if (out_valid && out_ready) win_count++;
      if (frame_done) done_count++;
    end
  end

  // Drive one cycle of inputs; acc reports whether the pixel was taken.
  task automatic applyStimulus(input logic [DW-1:0] p, input bit v, input bit rdy, output bit acc);
    in_pixel  = p;
    in_valid  = v;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready && !rst;
    @(posedge clk);
    #1;
  endtask

  task automatic sendPixel(input int p);
    bit acc;
    int n;
    n = 0;
    do begin
      applyStimulus(6'(p), 1'b1, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) checkOutput("accept timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b1, acc);
  endtask

  int wb, db, sum;
  bit acc0;

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1;
    checkOutput("reset out_valid",  64'(out_valid),  64'(0));
    checkOutput("reset frame_done", 64'(frame_done), 64'(0));
    checkOutput("reset taps",       64'(dut_taps),   64'(0));
    checkOutput("reset row/col",    64'({out_row, out_col}), 64'(0));

    // Basic 4x4 frame
    wb = win_count; db = done_count;
    for (int i = 0; i < 16; i++) begin
      sendPixel(i);
      if (i == 10) begin
        checkOutput("basic first taps",  64'(dut_taps), 64'(pack9(0,1,2,4,5,6,8,9,10)));
        checkOutput("basic first valid", 64'(out_valid), 64'(1));
        checkOutput("basic first pos",   64'({out_row, out_col}), 64'({2'd1, 2'd1}));
      end
      if (i == 15) begin
        checkOutput("basic last taps", 64'(dut_taps), 64'(pack9(5,6,7,9,10,11,13,14,15)));
        checkOutput("basic last pos",  64'({out_row, out_col}), 64'({2'd2, 2'd2}));
        checkOutput("basic last done", 64'(frame_done), 64'(1));
      end
    end
    idle(2);
    checkOutput("basic windows", 64'(win_count - wb), 64'(4));
    checkOutput("basic done",    64'(done_count - db), 64'(1));

    // Backpressure on the first window
    wb = win_count;
    for (int i = 0; i <= 10; i++) sendPixel(i);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'd11, 1'b1, 1'b0, acc0);
      checkOutput("bp accepted", 64'(acc0), 64'(0));
      checkOutput("bp taps",     64'(dut_taps), 64'(pack9(0,1,2,4,5,6,8,9,10)));
      checkOutput("bp pos",      64'({out_row, out_col}), 64'({2'd1, 2'd1}));
      checkOutput("bp valid",    64'(out_valid), 64'(1));
    end
    for (int i = 11; i < 16; i++) sendPixel(i);
    idle(2);
    checkOutput("bp windows", 64'(win_count - wb), 64'(4));

    // Back-to-back frames
    wb = win_count; db = done_count;
    for (int i = 0; i < 32; i++) begin
      sendPixel(i < 16 ? i : 100 + i - 16);
      if (i == 26)
        checkOutput("b2b second first taps", 64'(dut_taps),
                    64'(pack9(100,101,102,104,105,106,108,109,110)));
    end
    idle(2);
    checkOutput("b2b windows", 64'(win_count - wb), 64'(8));
    checkOutput("b2b done",    64'(done_count - db), 64'(2));

    // Maximum pixel values with an all-ones kernel reference
    wb = win_count;
    for (int i = 0; i < 16; i++) begin
      sendPixel(63);
      if (i == 10) begin
        checkOutput("max taps", 64'(dut_taps), 64'(pack9(63,63,63,63,63,63,63,63,63)));
        sum = int'(win_0) + int'(win_1) + int'(win_2) + int'(win_3) + int'(win_4)
            + int'(win_5) + int'(win_6) + int'(win_7) + int'(win_8);
        checkOutput("max conv sum", 64'(sum), 64'(567));
      end
    end
    idle(2);
    checkOutput("max windows", 64'(win_count - wb), 64'(4));

    // Reset mid-frame after pixel 9
    for (int i = 0; i <= 9; i++) sendPixel(i);
    rst = 1'b1;
    applyStimulus(6'd10, 1'b1, 1'b1, acc0);
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst out_valid", 64'(out_valid), 64'(0));
    wb = win_count;
    for (int i = 0; i < 16; i++) begin
      sendPixel(i);
      if (i == 10)
        checkOutput("rst first taps", 64'(dut_taps), 64'(pack9(0,1,2,4,5,6,8,9,10)));
    end
    idle(2);
    checkOutput("rst windows", 64'(win_count - wb), 64'(4));

    // Random valid/ready stalls over continuous frames
    for (int i = 0; i < 1000; i++)
      applyStimulus(6'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc0);
    in_valid = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/conv33_window_gen.md
# conv33_window_gen

Streaming 3x3 window generator that sits directly upstream of the 6-bit PIM 3x3 convolution stage (`conv33_6bit_PIM`). It accepts one raster-ordered 6-bit pixel per handshake, buffers the two previous image rows, and presents each complete 3x3 neighbourhood as nine parallel taps. The tap ordering matches the convolution's `in_data_0..in_data_8` inputs. Only full windows are emitted (no padding), and output backpressure is supported through a single registered output stage.

## Interface
- `DATA_W`, 6, pixel width in bits; must equal the convolution input width.
- `IMG_W`, 8, image width in pixels; minimum 3.
- `IMG_H`, 8, image height in rows; minimum 3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_pixel` input DATA_W: raster-order pixel, row-major, left to right.
- `in_valid` input 1: `in_pixel` is valid.
- `in_ready` output 1: block accepts a pixel this cycle.
- `win_0`..`win_8` output DATA_W each: window taps in row-major order. `win_0` is the top-left pixel at (r-2, c-2), `win_4` is the centre, and `win_8` is the newest pixel at (r, c).
- `out_valid` output 1: taps hold a valid window.
- `out_ready` input 1: downstream consumes the window.
- `out_row` output clog2(IMG_H): row of the window centre (r-1).
- `out_col` output clog2(IMG_W): column of the window centre (c-1).
- `frame_done` output 1: one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- Accept condition: `in_valid && in_ready`, where `in_ready = !out_valid || out_ready`. Input is blocked while an un-consumed window is held, even when the incoming pixel would not complete a window.
- Counters:
  - Column counter `c` runs 0..IMG_W-1. Row counter `r` runs 0..IMG_H-1.
  - On each accept, `c` increments. At `c == IMG_W-1`, `c` wraps to 0 and `r` increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0 and `frame_done` pulses.
- Line buffers: two arrays of IMG_W words, `lb0` (previous row) and `lb1` (row before that). On accept at column `c`: `lb1[c] <= lb0[c]` and `lb0[c] <= in_pixel`.
- Window shift register: 3x3 registers. On accept, each row shifts left by one column, and the new right column becomes {`lb1[c]`, `lb0[c]`, `in_pixel`}, read before the line-buffer update.
- Emit condition: `r >= 2 && c >= 2` at accept time. On emit:
  - The output register loads the nine taps with the post-shift window.
  - `out_row` loads r-1 and `out_col` loads c-1.
  - `out_valid` is set.
- Non-emitting accepts (r < 2 or c < 2) leave the output register unchanged. `out_valid` is cleared if `out_ready` consumed it that cycle.
- Windows per frame: (IMG_H-2)*(IMG_W-2). Stale line-buffer or shift-register contents from a previous frame or row are never emitted, because the emit gating guarantees all nine taps come from the current frame.
- Output holding: `out_valid && !out_ready` holds all outputs stable. `out_valid && out_ready` with a simultaneous emitting accept loads the new window in the same cycle, so `out_valid` stays 1.
- Reset:
  - Clears `r`, `c`, `out_valid`, and `frame_done` to 0, and clears `out_row`, `out_col`, and all `win_*` to 0.
  - Line buffers and the shift register need not be cleared.
  - Reset mid-frame abandons the partial frame; the next accepted pixel is treated as (0,0).

## Timing
- Latency: the window completed by the pixel accepted in cycle N is visible on `win_*`/`out_valid` in cycle N+1.
- Throughput: one pixel per cycle with `out_ready` held high; no bubbles at row or frame boundaries.
- `frame_done` is high in cycle N+1 for exactly one cycle after the last pixel is accepted in cycle N. It coincides with `out_valid` for the final window (centre at IMG_H-2, IMG_W-2).
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- During `rst`, `in_ready` reads 1 (because `out_valid` is 0); pixels presented during reset are not accepted.

## Test plan
- **Basic window, IMG_W=IMG_H=4:** stream pixels 0..15 with `out_ready=1`.
  - Exactly 4 windows result.
  - First window = {0,1,2,4,5,6,8,9,10} at (1,1), one cycle after pixel 10.
  - Last window = {5,6,7,9,10,11,13,14,15} at (2,2), with `frame_done` in the same cycle.
- **Backpressure:** drop `out_ready` for 3 cycles while a window is held.
  - Taps, `out_row`, and `out_col` stay stable and `in_ready` is 0.
  - No pixel is lost: the full output sequence matches the no-stall golden.
- **Back-to-back frames:** stream two 4x4 frames without gaps, the second frame with pixels 100..115 masked to 6 bits.
  - The second frame's first window contains only second-frame pixels.
  - There are 8 windows total and 2 `frame_done` pulses.
- **Max values, default 8x8:** all pixels = 63.
  - 36 windows result, with every tap = 63.
  - Feeding a reference convolution model, the output matches.
- **Reset mid-frame:** assert `rst` for 1 cycle after pixel 9 of a 4x4 frame.
  - `out_valid` is 0 next cycle.
  - Restreaming 0..15 yields the same 4 windows as the basic test.
- **Random stalls:** randomise `in_valid`/`out_ready` over 1000 cycles on an 8x8 frame.
  - Windows match the golden model in order.
  - `out_valid` never drops without a handshake.
